gray_step_checker: RTL

Downstream consumer of the 3-bit gray counter. Samples the counter's gray output and overflow flag on every enabled cycle and decodes the value to binary. Checks that each accepted sample is a legal gray step: hold, or +1 modulo 2^W with overflow consistent with the wrap. Counts wraps and step errors, and tracks a lock state so the surrounding test/debug logic can confirm counter health without inspecting raw codes.

---
 rtl/gray_step_checker.sv | 110 +++++++++++
 1 files changed

// File: rtl/gray_step_checker.sv
`default_nettype none
// ============================================================================
// gray_step_checker : decodes sampled gray codes, checks legal steps, counts wraps/errors
// Revision 1.0
// ============================================================================
module gray_step_checker #(
  parameter int W  = 3,
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Sample,
  input  logic          Resync,
  input  logic [W-1:0]  Gray_In,
  input  logic          Ovf_In,
  output logic [W-1:0]  Bin_Out,
  output logic [CW-1:0] Wrap_Cnt,
  output logic          Step_Err,
  output logic [CW-1:0] Err_Cnt,
  output logic          Locked
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};

  state_t         r_state;
  logic           r_good;
  logic [W-1:0]   w_bnew;
  logic [W-1:0]   w_d;
  logic           w_legal;
  logic           w_wrap;

  // Each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    w_bnew = '0;
    for (int i = 0; i < W; i++) begin
      w_bnew[i] = ^(Gray_In >> i);
    end
  end

  assign w_d     = w_bnew - Bin_Out;
  assign w_wrap  = (w_d == W'(1)) && (w_bnew == '0);
  assign w_legal = ((w_d == '0) && !Ovf_In) ||
                   ((w_d == W'(1)) && (Ovf_In == (w_bnew == '0)));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_good   <= 1'b0;
      Bin_Out  <= '0;
      Wrap_Cnt <= '0;
      Err_Cnt  <= '0;
      Step_Err <= 1'b0;
      Locked   <= 1'b0;
    end else begin
      Step_Err <= 1'b0;
      if (Resync) begin
        r_state <= ST_IDLE;
        r_good  <= 1'b0;
        Locked  <= 1'b0;
      end else if (Sample) begin
        Bin_Out <= w_bnew;
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_TRACK;
            Locked  <= 1'b1;
          end
          ST_TRACK: begin
            if (w_legal) begin
              if (w_wrap && (Wrap_Cnt != c_cnt_max)) Wrap_Cnt <= Wrap_Cnt + CW'(1);
            end else begin
              Step_Err <= 1'b1;
              if (Err_Cnt != c_cnt_max) Err_Cnt <= Err_Cnt + CW'(1);
              r_good   <= 1'b0;
              r_state  <= ST_FAULT;
              Locked   <= 1'b0;
            end
          end
          ST_FAULT: begin
            if (w_legal) begin
              // Two consecutive legal steps are needed to trust the counter again.
              if (r_good) begin
                r_good  <= 1'b0;
                r_state <= ST_TRACK;
                Locked  <= 1'b1;
              end else begin
                r_good <= 1'b1;
              end
            end else begin
              Step_Err <= 1'b1;
              if (Err_Cnt != c_cnt_max) Err_Cnt <= Err_Cnt + CW'(1);
              r_good   <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            Locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
